// File: rtl/nabp_swap_control.sv
// nabp_swap_control
// Angle scheduler for a pair of swappable projection units. Walks the
// angle range, fetches the per-angle accumulator constants from an external
// LUT, hands each angle to a requesting unit, and pulses a joint swap once
// every unit served in the round is ready. Pulses done after the final swap.
//
// Optional feature macro: NABP_SWAP_CONTROL_RR_EN
//   defined   : round-robin priority between the two units
//   undefined : unit 0 always wins simultaneous requests (no prio register)
module nabp_swap_control #(
   parameter int ANGLE_LEN   = 9,
   parameter int ANGLE_START = 0,
   parameter int ANGLE_END   = 179,
   parameter int ANGLE_STEP  = 1,
   parameter int SH_W        = 16,
   parameter int MI_W        = 16,
   parameter int MB_W        = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 kick,
   output logic                 busy,
   output logic                 done,
   output logic [ANGLE_LEN-1:0] lut_angle,
   input  logic [SH_W-1:0]      lut_sh_accu_base,
   input  logic [MI_W-1:0]      lut_mp_accu_init,
   input  logic [MB_W-1:0]      lut_mp_accu_base,
   output logic [ANGLE_LEN-1:0] sw_angle,
   output logic [SH_W-1:0]      sw_sh_accu_base,
   output logic [MI_W-1:0]      sw_mp_accu_init,
   output logic [MB_W-1:0]      sw_mp_accu_base,
   input  logic [1:0]           sw_next_itr,
   output logic [1:0]           sw_next_itr_ack,
   input  logic [1:0]           sw_swap_ready,
   output logic [1:0]           sw_swap
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_SWAP,
      S_FIN
   } state_t;

   // One extra bit so the running angle never wraps past ANGLE_END.
   localparam logic [ANGLE_LEN:0] L_START = (ANGLE_LEN+1)'(ANGLE_START);
   localparam logic [ANGLE_LEN:0] L_END   = (ANGLE_LEN+1)'(ANGLE_END);
   localparam logic [ANGLE_LEN:0] L_STEP  = (ANGLE_LEN+1)'(ANGLE_STEP);

   state_t               r_state;
   logic [ANGLE_LEN:0]   r_angle;
   logic [1:0]           r_served;
   logic                 r_last;
   logic                 r_done;
   logic [1:0]           r_ack;
   logic [1:0]           r_swap;
   logic [ANGLE_LEN-1:0] r_sw_angle;
   logic [SH_W-1:0]      r_sw_sh_accu_base;
   logic [MI_W-1:0]      r_sw_mp_accu_init;
   logic [MB_W-1:0]      r_sw_mp_accu_base;

   logic                 w_prio;
   logic [1:0]           w_elig;
   logic [1:0]           w_grant;
   logic [1:0]           w_served_new;
   logic [ANGLE_LEN:0]   w_angle_next;
   logic                 w_last_new;
   logic                 w_swap_ok;

`ifdef NABP_SWAP_CONTROL_RR_EN
   logic                 r_prio;

   // Round-robin pointer: hand priority to the loser of a contested grant.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prio <= 1'b0;
      end else if (r_state == S_ISSUE && w_elig == 2'b11) begin
         r_prio <= ~r_prio;
      end
   end

   assign w_prio = r_prio;
`else
   assign w_prio = 1'b0;
`endif

   // Units that are asking and have not yet been served this round.
   assign w_elig       = sw_next_itr & ~r_served;
   assign w_served_new = r_served | w_grant;
   assign w_angle_next = r_angle + L_STEP;
   assign w_last_new   = (w_angle_next > L_END);
   assign w_swap_ok    = ((sw_swap_ready & r_served) == r_served);

   // Pick exactly one eligible unit; priority only matters on a tie.
   always_comb begin
      w_grant = '0;
      if (w_elig == 2'b11) begin
         w_grant[w_prio] = 1'b1;
      end else if (w_elig[0]) begin
         w_grant = 2'b01;
      end else if (w_elig[1]) begin
         w_grant = 2'b10;
      end
   end

   // Frame sequencer with registered handshake outputs and config bus.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state           <= S_IDLE;
         r_angle           <= '0;
         r_served          <= '0;
         r_last            <= 1'b0;
         r_done            <= 1'b0;
         r_ack             <= '0;
         r_swap            <= '0;
         r_sw_angle        <= '0;
         r_sw_sh_accu_base <= '0;
         r_sw_mp_accu_init <= '0;
         r_sw_mp_accu_base <= '0;
      end else begin
         r_ack  <= '0;
         r_swap <= '0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (kick) begin
                  r_angle  <= L_START;
                  r_served <= '0;
                  r_last   <= 1'b0;
                  r_state  <= S_FETCH;
               end
            end
            S_FETCH: begin
               // lut_angle follows r_angle; data is valid in ISSUE.
               r_state <= S_ISSUE;
            end
            S_ISSUE: begin
               if (w_elig != 2'b00) begin
                  r_sw_angle        <= r_angle[ANGLE_LEN-1:0];
                  r_sw_sh_accu_base <= lut_sh_accu_base;
                  r_sw_mp_accu_init <= lut_mp_accu_init;
                  r_sw_mp_accu_base <= lut_mp_accu_base;
                  r_ack             <= w_grant;
                  r_served          <= w_served_new;
                  r_angle           <= w_angle_next;
                  if (w_last_new) begin
                     r_last <= 1'b1;
                  end
                  if (w_served_new == 2'b11 || w_last_new) begin
                     r_state <= S_SWAP;
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end
            S_SWAP: begin
               if (w_swap_ok) begin
                  r_swap   <= r_served;
                  r_served <= '0;
                  r_state  <= r_last ? S_FIN : S_FETCH;
               end
            end
            S_FIN: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy            = (r_state != S_IDLE);
   assign done            = r_done;
   assign lut_angle       = r_angle[ANGLE_LEN-1:0];
   assign sw_angle        = r_sw_angle;
   assign sw_sh_accu_base = r_sw_sh_accu_base;
   assign sw_mp_accu_init = r_sw_mp_accu_init;
   assign sw_mp_accu_base = r_sw_mp_accu_base;
   assign sw_next_itr_ack = r_ack;
   assign sw_swap         = r_swap;

endmodule

// File: tb/tb_nabp_swap_control.sv
// Directed bench for nabp_swap_control: angles 2..6 (five angles, so the
// last round is odd), LUT returns angle*3 / angle+100 / angle^0x5a5a.
module tb_nabp_swap_control;

   localparam int AL = 9;

`ifdef NABP_SWAP_CONTROL_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          kick;
   logic          busy;
   logic          done;
   logic [AL-1:0] lut_angle;
   logic [15:0]   lut_sh_accu_base;
   logic [15:0]   lut_mp_accu_init;
   logic [15:0]   lut_mp_accu_base;
   logic [AL-1:0] sw_angle;
   logic [15:0]   sw_sh_accu_base;
   logic [15:0]   sw_mp_accu_init;
   logic [15:0]   sw_mp_accu_base;
   logic [1:0]    sw_next_itr;
   logic [1:0]    sw_next_itr_ack;
   logic [1:0]    sw_swap_ready;
   logic [1:0]    sw_swap;

   int total = 0;
   int bad   = 0;

   nabp_swap_control #(
      .ANGLE_LEN(AL), .ANGLE_START(2), .ANGLE_END(6), .ANGLE_STEP(1),
      .SH_W(16), .MI_W(16), .MB_W(16)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .kick(kick), .busy(busy), .done(done),
      .lut_angle(lut_angle),
      .lut_sh_accu_base(lut_sh_accu_base),
      .lut_mp_accu_init(lut_mp_accu_init),
      .lut_mp_accu_base(lut_mp_accu_base),
      .sw_angle(sw_angle),
      .sw_sh_accu_base(sw_sh_accu_base),
      .sw_mp_accu_init(sw_mp_accu_init),
      .sw_mp_accu_base(sw_mp_accu_base),
      .sw_next_itr(sw_next_itr), .sw_next_itr_ack(sw_next_itr_ack),
      .sw_swap_ready(sw_swap_ready), .sw_swap(sw_swap)
   );

   always #5 clk = ~clk;

   // Synchronous LUT: data one cycle after the address.
   always @(posedge clk) begin
      lut_sh_accu_base <= 16'(lut_angle) * 16'd3;
      lut_mp_accu_init <= 16'(lut_angle) + 16'd100;
      lut_mp_accu_base <= 16'(lut_angle) ^ 16'h5a5a;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_bus(input int unsigned ang);
      check("sw_angle", 32'(sw_angle), 32'(ang));
      check("sw_sh", 32'(sw_sh_accu_base), 32'(ang * 3));
      check("sw_mi", 32'(sw_mp_accu_init), 32'(ang + 100));
      check("sw_mb", 32'(sw_mp_accu_base), 32'(ang ^ 32'h5a5a));
   endtask

   task automatic expect_grant(input logic [1:0] g, input int unsigned ang);
      int unsigned n = 0;
      tick();
      while (sw_next_itr_ack == 2'b00 && n < 12) begin
         tick();
         n++;
      end
      if (sw_next_itr_ack == 2'b00) begin
         total++;
         bad++;
         $error("FAIL grant_wait: observed=no ack expected=ack %b angle %0d", g, ang);
      end else begin
         check("ack", 32'(sw_next_itr_ack), 32'(g));
         check_bus(ang);
      end
   endtask

   task automatic expect_swap(input logic [1:0] s);
      int unsigned n = 0;
      tick();
      while (sw_swap == 2'b00 && n < 12) begin
         tick();
         n++;
      end
      if (sw_swap == 2'b00) begin
         total++;
         bad++;
         $error("FAIL swap_wait: observed=no swap expected=%b", s);
      end else begin
         check("swap", 32'(sw_swap), 32'(s));
      end
   endtask

   task automatic expect_done();
      int unsigned n = 0;
      tick();
      while (!done && n < 12) begin
         tick();
         n++;
      end
      if (!done) begin
         total++;
         bad++;
         $error("FAIL done_wait: observed=no done expected=done pulse");
      end else begin
         check("done_busy", 32'(busy), 32'(0));
      end
   endtask

   initial begin
      logic [1:0] g_last;
      reset_n       = 1'b0;
      kick          = 1'b0;
      sw_next_itr   = 2'b00;
      sw_swap_ready = 2'b11;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_ack", 32'(sw_next_itr_ack), 32'(0));
      check("rst_swap", 32'(sw_swap), 32'(0));
      check("rst_lut", 32'(lut_angle), 32'(0));
      check("rst_bus", 32'({sw_angle, sw_sh_accu_base}), 32'(0));
      check("rst_bus2", 32'({sw_mp_accu_init, sw_mp_accu_base}), 32'(0));
      reset_n = 1'b1;
      tick();

      // Frame 1: unit 0 first, then unit 1; cycle-exact latencies.
      kick = 1'b1;
      tick();
      kick = 1'b0;
      check("f1_busy", 32'(busy), 32'(1));
      check("f1_lut0", 32'(lut_angle), 32'(2));
      sw_next_itr = 2'b01;
      tick();
      check("f1_noack", 32'(sw_next_itr_ack), 32'(0));
      tick();
      check("f1_ack0", 32'(sw_next_itr_ack), 32'(2'b01));
      check_bus(2);
      sw_next_itr = 2'b11;
      tick();
      check("f1_ackpulse", 32'(sw_next_itr_ack), 32'(0));
      check("f1_hold", 32'(sw_angle), 32'(2));
      check("f1_hold_sh", 32'(sw_sh_accu_base), 32'(6));
      check("f1_lut1", 32'(lut_angle), 32'(3));
      tick();
      check("f1_ack1", 32'(sw_next_itr_ack), 32'(2'b10));
      check_bus(3);
      tick();
      check("f1_swap1", 32'(sw_swap), 32'(2'b11));
      sw_swap_ready = 2'b01;
      tick();
      tick();
      check("f1_ack2", 32'(sw_next_itr_ack), 32'(2'b01));
      check_bus(4);
      tick();
      tick();
      check("f1_ack3", 32'(sw_next_itr_ack), 32'(2'b10));
      check_bus(5);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("f1_swap_held", 32'(sw_swap), 32'(0));
      end
      sw_swap_ready = 2'b11;
      tick();
      check("f1_swap2", 32'(sw_swap), 32'(2'b11));
      tick();
      tick();
      g_last = RR ? 2'b10 : 2'b01;
      check("f1_ack4", 32'(sw_next_itr_ack), 32'(g_last));
      check_bus(6);
      tick();
      check("f1_swap3", 32'(sw_swap), 32'(g_last));
      check("f1_nodone", 32'(done), 32'(0));
      tick();
      check("f1_done", 32'(done), 32'(1));
      check("f1_idle", 32'(busy), 32'(0));
      tick();
      check("f1_donepulse", 32'(done), 32'(0));
      check("f1_hold_end", 32'(sw_angle), 32'(6));

      // Frame 2: both units request continuously.
      sw_next_itr = 2'b11;
      kick = 1'b1;
      tick();
      kick = 1'b0;
      expect_grant(2'b01, 2);
      expect_grant(2'b10, 3);
      expect_swap(2'b11);
      expect_grant(RR ? 2'b10 : 2'b01, 4);
      expect_grant(RR ? 2'b01 : 2'b10, 5);
      expect_swap(2'b11);
      expect_grant(2'b01, 6);
      expect_swap(2'b01);
      expect_done();

      // Frame 3: reset while waiting in ISSUE, then restart.
      sw_next_itr = 2'b00;
      tick();
      kick = 1'b1;
      tick();
      kick = 1'b0;
      tick();
      tick();
      check("f3_busy_pre", 32'(busy), 32'(1));
      reset_n = 1'b0;
      #1;
      check("f3_rst_busy", 32'(busy), 32'(0));
      check("f3_rst_lut", 32'(lut_angle), 32'(0));
      check("f3_rst_bus", 32'({sw_angle, sw_sh_accu_base}), 32'(0));
      check("f3_rst_bus2", 32'({sw_mp_accu_init, sw_mp_accu_base}), 32'(0));
      check("f3_rst_hs", 32'({sw_next_itr_ack, sw_swap, done}), 32'(0));
      tick();
      reset_n = 1'b1;
      tick();
      sw_next_itr = 2'b10;
      kick = 1'b1;
      tick();
      kick = 1'b0;
      check("f3_lut_restart", 32'(lut_angle), 32'(2));
      expect_grant(2'b10, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nabp_swap_control.md
# nabp_swap_control

Angle scheduler that sits above a pair of swappable projection units and sequences a full back-projection frame. For each angle from `ANGLE_START` to `ANGLE_END`, it fetches that angle's shifter and mapper accumulator constants from an external lookup table. It hands each angle to whichever unit requests the next iteration, then pulses a simultaneous swap once every unit served in the current round is swap-ready. It arbitrates between the two units' requests and signals `done` when the last angle has been swapped in.

## Interface
- `ANGLE_LEN`, 9: width of the angle value.
- `ANGLE_START`, 0: first angle issued.
- `ANGLE_END`, 179: last angle issued, inclusive.
- `ANGLE_STEP`, 1: angle increment; must be ≥1.
- `SH_W`, 16: width of the shifter accumulator base.
- `MI_W`, 16: width of the mapper accumulator init.
- `MB_W`, 16: width of the mapper accumulator base.

Ports (clock and reset first; reset is asynchronous, active-low):
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `kick`  in  1  start-of-frame pulse; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final swap.
- `lut_angle`  out  ANGLE_LEN  lookup-table address.
- `lut_sh_accu_base`  in  SH_W  lookup data, valid 1 cycle after `lut_angle`.
- `lut_mp_accu_init`  in  MI_W  lookup data, same timing.
- `lut_mp_accu_base`  in  MB_W  lookup data, same timing.
- `sw_angle`  out  ANGLE_LEN  shared configuration bus; registered.
- `sw_sh_accu_base`  out  SH_W  shared configuration bus; registered.
- `sw_mp_accu_init`  out  MI_W  shared configuration bus; registered.
- `sw_mp_accu_base`  out  MB_W  shared configuration bus; registered.
- `sw_next_itr`  in  2  bit i: unit i requests the next angle (level).
- `sw_next_itr_ack`  out  2  bit i: one-cycle grant; unit i latches the bus on this cycle.
- `sw_swap_ready`  in  2  bit i: unit i is ready to swap (level).
- `sw_swap`  out  2  one-cycle swap pulse to the units served this round.

## Operation
- State machine: IDLE, FETCH, ISSUE, SWAP, FIN.
- Registers:
  - `angle` (ANGLE_LEN+1 bits, so the counter never wraps).
  - `served` (2 bits).
  - `prio` (1 bit).
  - `last` (1 bit).
- IDLE:
  - `kick` loads `angle`=ANGLE_START, `served`=0, `last`=0, then goes to FETCH.
  - `kick` is ignored in every other state.
- FETCH (1 cycle):
  - Drive `lut_angle`=`angle`, then go to ISSUE.
- ISSUE:
  - Eligible set = `sw_next_itr & ~served`. Wait while it is empty.
  - Grant one eligible unit:
    - If both are eligible, grant unit `prio`.
    - Otherwise grant the single eligible unit.
  - On the grant cycle:
    - Register the lut data and `angle` onto the `sw_*` bus; they appear on the bus in the same cycle as the ack.
    - Pulse `sw_next_itr_ack[g]`.
    - Set `served[g]`.
    - Set `angle`+=ANGLE_STEP.
    - If `angle`+ANGLE_STEP > ANGLE_END, set `last`=1.
  - Next state:
    - `served`==2'b11 or `last` → SWAP.
    - Otherwise → FETCH.
- The `sw_*` bus holds its value until the next grant.
- SWAP:
  - Wait until `(sw_swap_ready & served)==served`.
  - Then pulse `sw_swap`=`served` for one cycle and clear `served`.
  - Next state: FIN if `last`, else FETCH.
  - Units not served in the round (odd final round) receive no swap.
- FIN (1 cycle): pulse `done`, then go to IDLE.
- Comparison uses ANGLE_LEN+1 bits. ANGLE_START > ANGLE_END is illegal and not checked.

## Timing
- Reset values:
  - state=IDLE.
  - `busy`, `done`, `sw_next_itr_ack`, `sw_swap`=0.
  - `lut_angle`, `sw_angle`=0.
  - All accumulator outputs=0.
- Reset asserted mid-frame aborts immediately. Any partially issued round is discarded; units must be reset together with this block.
- Latencies:
  - `kick` → first `lut_angle` valid: 1 cycle.
  - FETCH → earliest ack: 2 cycles.
  - Swap-ready condition met → `sw_swap`: 1 cycle.
  - Final `sw_swap` → `done`: 1 cycle.
- A request withdrawn before its grant is not served.
- A request that is still high after its unit is served is ignored until the next round.
- Simultaneous requests cost one extra FETCH/ISSUE per additional unit. Only one ack is issued per cycle.

## Configuration
- `NABP_SWAP_CONTROL_RR_EN` defined:
  - `prio` toggles to the non-granted unit whenever both units were eligible in the same cycle.
  - Round-robin fairness.
- Not defined:
  - `prio` is tied to 0: unit 0 always wins simultaneous requests.
  - The `prio` register is not built.

## Test plan
- ANGLE_START=0, END=3, STEP=1, unit 0 requests first, then unit 1; both ready immediately:
  - acks on angles 0,1 → `sw_swap`=2'b11.
  - acks on angles 2,3 → `sw_swap`=2'b11.
  - `done` one cycle after the second swap; 4 acks total.
- END=2:
  - the second round issues angle 2 to the first requester only.
  - `sw_swap` equals that unit's bit alone; then `done`.
- Both units request continuously with END=3:
  - RR_EN defined: grant order 0,1,1,0.
  - RR_EN undefined: grant order 0,1,0,1.
- LUT returns `sh_accu_base`=angle*3:
  - on each ack, `sw_sh_accu_base` equals 3×`sw_angle`.
  - the bus holds that value until the next ack.
- `sw_swap_ready`=2'b01 held 20 cycles after a full round:
  - no `sw_swap` during those cycles.
  - raise bit 1 → `sw_swap`=2'b11 one cycle later.
- Reset mid-ISSUE:
  - all outputs 0 and `busy`=0 at once.
  - a new `kick` restarts from ANGLE_START.
